mux_2x1_rr_arbiter: RTL and testbench
=====================================

// Module: mux_2x1_rr_arbiter
//
// PURPOSE
//   Shares one mux_2x1-style output path between two valid/ready requesters (A, B).
//   Round-robin arbitration, one-deep registered output stage. sel drives the
//   downstream 2:1 mux select.
//   Sits between two producer streams and a single consumer stream.
//
// PARAMETERS
//   DATA_W   8   payload width of a_data, b_data, y_data
//
// PORTS
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   a_valid  in   1        requester A has a beat
//   a_data   in   DATA_W   requester A payload
//   a_last   in   1        A beat ends a packet (used only with MUX_ARB_LOCK_EN)
//   a_ready  out  1        A beat accepted this cycle when a_valid && a_ready
//   b_valid  in   1        requester B has a beat
//   b_data   in   DATA_W   requester B payload
//   b_last   in   1        B beat ends a packet (used only with MUX_ARB_LOCK_EN)
//   b_ready  out  1        B beat accepted this cycle when b_valid && b_ready
//   y_valid  out  1        output beat valid (registered)
//   y_data   out  DATA_W   output payload (registered)
//   y_last   out  1        output last flag (registered)
//   y_ready  in   1        consumer accepts output when y_valid && y_ready
//   sel      out  1        current grant: 0 = A, 1 = B (combinational)
//
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - y_valid=0, y_data=0, y_last=0, state=IDLE, prio=A.
//     - While in reset: a_ready=0, b_ready=0, sel=0.
//     - Reset mid-transfer drops any held beat; no output for 1 clk after release.
//   out_free = !y_valid || y_ready. A beat is loaded into the output register in
//   the same cycle it is accepted.
//   Latency: accepted beat appears on y_* on the next rising edge (1 cycle).
//   Throughput: 1 beat/clk when y_ready is held high.
//   FSM states: IDLE, BUSY_A, BUSY_B.
//     IDLE:
//       - grant = the sole valid requester.
//       - Both valid: grant = prio.
//       - Neither valid: grant = prio, no transfer.
//     BUSY_A: grant = A regardless of b_valid.
//     BUSY_B: grant = B regardless of a_valid.
//   sel = grant. x_ready = out_free && (grant == x). The non-granted ready is
//   always 0.
//   On acceptance of a beat from x with effective last = 1:
//     - state -> IDLE, prio -> other requester.
//   On acceptance with effective last = 0:
//     - state -> BUSY_x, prio unchanged.
//   No acceptance: state and prio hold.
//   y_valid clears on y_ready when no new beat is accepted. The output register
//   holds y_data and y_last stable while y_valid && !y_ready.
//   Simultaneous y_ready and a new accept: the register is overwritten, y_valid
//   stays 1.
//   Granted requester drops valid mid-packet (BUSY_x): state holds and the other
//   requester is stalled.
//
// CONFIGURATION
//   MUX_ARB_LOCK_EN defined:
//     - effective last = a_last / b_last of the accepted beat.
//     - Grant is held for a whole packet.
//     - y_last = accepted beat's last.
//   MUX_ARB_LOCK_EN undefined:
//     - effective last forced to 1, so the FSM never leaves IDLE.
//     - Arbitration is per beat and alternates A/B under contention.
//     - a_last and b_last are ignored; y_last is driven 1 with every beat.
//
// TESTING
//   1. Reset, then release with a_valid=b_valid=0
//      -> y_valid=0, sel=0, a_ready=1, b_ready=0.
//   2. Only A valid, y_ready=1, a_data=0x11,0x22 on back-to-back clks
//      -> y_data=0x11 then 0x22, one cycle after each accept.
//   3. Both valid continuously, y_ready=1, lock off (A=0xA0.., B=0xB0..)
//      -> y_data alternates 0xA0,0xB0,0xA1,0xB1; sel toggles each clk.
//   4. y_ready=0 with y_valid=1 for 3 clks
//      -> y_data stable, a_ready=b_ready=0; the held beat drains on the first
//         y_ready=1.
//   5. Lock on: A sends 3 beats (last on 3rd) while B is valid
//      -> all 3 A beats are output before any B beat; then B is granted and
//         sel=1.
//   6. rst_n pulsed low while in BUSY_B with y_valid=1
//      -> y_valid=0 immediately; after release, state=IDLE and prio=A.

Source files
------------

// File: rtl/mux_2x1_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage between two requesters.
// Optional packet locking is enabled by defining MUX_ARB_LOCK_EN.
module mux_2x1_rr_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              b_ready,
    output logic              y_valid,
    output logic [DATA_W-1:0] y_data,
    output logic              y_last,
    input  logic              y_ready,
    output logic              sel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_A = 2'd1,
        ST_BUSY_B = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              prio_q;
    logic              prio_d;
    logic              y_valid_q;
    logic              y_valid_d;
    logic [DATA_W-1:0] y_data_q;
    logic [DATA_W-1:0] y_data_d;
    logic              y_last_q;
    logic              y_last_d;

    logic              grant_s;
    logic              out_free_s;
    logic              accept_s;
    logic              eff_last_s;
    logic [DATA_W-1:0] acc_data_s;

`ifdef MUX_ARB_LOCK_EN
    assign eff_last_s = grant_s ? b_last : a_last;
`else
    // Per-beat arbitration: every beat closes its own "packet".
    logic unused_last_s;
    assign unused_last_s = a_last ^ b_last;
    assign eff_last_s    = 1'b1;
`endif

    // Grant selection: locked owner in BUSY_x, otherwise sole requester or priority.
    always_comb begin
        grant_s = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (a_valid && !b_valid) begin
                    grant_s = 1'b0;
                end else if (!a_valid && b_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = prio_q;
                end
            end
            ST_BUSY_A: grant_s = 1'b0;
            ST_BUSY_B: grant_s = 1'b1;
            default:   grant_s = prio_q;
        endcase
    end

    assign out_free_s = !y_valid_q || y_ready;
    // Handshakes are forced low while reset is asserted.
    assign a_ready    = rst_n && out_free_s && !grant_s;
    assign b_ready    = rst_n && out_free_s && grant_s;
    assign sel        = rst_n && grant_s;
    assign accept_s   = grant_s ? (b_valid && b_ready) : (a_valid && a_ready);
    assign acc_data_s = grant_s ? b_data : a_data;

    // Next-state and priority update on each accepted beat.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        if (accept_s) begin
            if (eff_last_s) begin
                state_d = ST_IDLE;
                prio_d  = !grant_s;
            end else begin
                state_d = grant_s ? ST_BUSY_B : ST_BUSY_A;
                prio_d  = prio_q;
            end
        end else begin
            state_d = state_q;
            prio_d  = prio_q;
        end
    end

    // Output stage: load on accept, drain on y_ready, otherwise hold.
    always_comb begin
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        y_last_d  = y_last_q;
        if (accept_s) begin
            y_valid_d = 1'b1;
            y_data_d  = acc_data_s;
            y_last_d  = eff_last_s;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end else begin
            y_valid_d = y_valid_q;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Output payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_valid_q <= 1'b0;
            y_data_q  <= {DATA_W{1'b0}};
            y_last_q  <= 1'b0;
        end else begin
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_last_q  <= y_last_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_last  = y_last_q;

endmodule

// File: tb/tb_mux_2x1_rr_arbiter.sv
// Directed self-checking bench for mux_2x1_rr_arbiter (default and MUX_ARB_LOCK_EN builds).
module tb_mux_2x1_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_last;
    logic       y_ready;
    logic       sel;

    int checks;
    int failures;

    mux_2x1_rr_arbiter #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_last  (a_last),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_last  (b_last),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_ready (y_ready),
        .sel     (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
        a_last = 1'b1; b_last = 1'b1; y_ready = 1'b0;
        #12;
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rst_y_valid actual=%b expected=0", y_valid); end
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready actual=%b expected=0", a_ready); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rst_b_ready actual=%b expected=0", b_ready); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rst_sel actual=%b expected=0", sel); end
        checks++; if (y_data !== 8'h00) begin failures++; $display("FAIL rst_y_data actual=%h expected=00", y_data); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rel_y_valid actual=%b expected=0", y_valid); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL rel_sel actual=%b expected=0", sel); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rel_a_ready actual=%b expected=1", a_ready); end
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL rel_b_ready actual=%b expected=0", b_ready); end
    endtask

    task automatic test_single_a();
        y_ready = 1'b1; a_valid = 1'b1; a_last = 1'b1; a_data = 8'h11;
        #1;
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL single_a_ready actual=%b expected=1", a_ready); end
        step();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h11) begin failures++; $display("FAIL single_beat0 actual=%b/%h expected=1/11", y_valid, y_data); end
        checks++; if (y_last !== 1'b1) begin failures++; $display("FAIL single_last actual=%b expected=1", y_last); end
        a_data = 8'h22;
        step();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h22) begin failures++; $display("FAIL single_beat1 actual=%b/%h expected=1/22", y_valid, y_data); end
        a_valid = 1'b0;
        step();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL single_drain actual=%b expected=0", y_valid); end
    endtask

    task automatic test_alternate();
        logic [7:0] exp_y [4];
        logic       exp_sel [4];
        exp_y[0] = 8'hA0; exp_y[1] = 8'hB0; exp_y[2] = 8'hA1; exp_y[3] = 8'hB1;
        exp_sel[0] = 1'b0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b0; exp_sel[3] = 1'b1;
        // prio is B after two A beats; one lone B beat hands priority back to A
        b_valid = 1'b1; b_last = 1'b1; b_data = 8'h55;
        #1;
        checks++; if (sel !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL lone_b sel/ready actual=%b/%b expected=1/1", sel, b_ready); end
        step();
        checks++; if (y_data !== 8'h55) begin failures++; $display("FAIL lone_b_data actual=%h expected=55", y_data); end
        a_valid = 1'b1; a_data = 8'hA0; b_data = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL alt_sel[%0d] actual=%b expected=%b", i, sel, exp_sel[i]); end
            step();
            checks++; if (y_valid !== 1'b1 || y_data !== exp_y[i]) begin failures++; $display("FAIL alt_y[%0d] actual=%b/%h expected=1/%h", i, y_valid, y_data, exp_y[i]); end
            if (exp_sel[i] == 1'b0) a_data = a_data + 8'h01;
            else b_data = b_data + 8'h01;
        end
    endtask

    task automatic test_backpressure();
        // Both still valid (A2/B2), y holds B1, prio = A
        y_ready = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready actual=%b/%b expected=0/0", a_ready, b_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (y_valid !== 1'b1 || y_data !== 8'hB1) begin failures++; $display("FAIL bp_hold[%0d] actual=%b/%h expected=1/b1", i, y_valid, y_data); end
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] actual=%b/%b expected=0/0", i, a_ready, b_ready); end
        end
        y_ready = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b1 || sel !== 1'b0) begin failures++; $display("FAIL bp_release actual=%b/%b expected=1/0", a_ready, sel); end
        step();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'hA2) begin failures++; $display("FAIL bp_drain actual=%b/%h expected=1/a2", y_valid, y_data); end
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL bp_empty actual=%b expected=0", y_valid); end
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        logic [7:0] a_seq [3];
        a_seq[0] = 8'h31; a_seq[1] = 8'h32; a_seq[2] = 8'h33;
        // prio is B here; A starts alone, then B joins and must wait for a_last
        y_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_data = a_seq[i];
            a_last = (i == 2) ? 1'b1 : 1'b0;
            #1;
            checks++; if (sel !== 1'b0 || b_ready !== 1'b0) begin failures++; $display("FAIL lock_sel[%0d] actual=%b/%b expected=0/0", i, sel, b_ready); end
            step();
            checks++; if (y_data !== a_seq[i] || y_last !== a_last) begin failures++; $display("FAIL lock_y[%0d] actual=%h/%b expected=%h/%b", i, y_data, y_last, a_seq[i], a_last); end
            b_valid = 1'b1; b_data = 8'hB5; b_last = 1'b0;
        end
        #1;
        checks++; if (sel !== 1'b1 || b_ready !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL lock_handover actual=%b/%b/%b expected=1/1/0", sel, b_ready, a_ready); end
        step();
        checks++; if (y_data !== 8'hB5 || y_last !== 1'b0) begin failures++; $display("FAIL lock_b_beat actual=%h/%b expected=b5/0", y_data, y_last); end
        // now BUSY_B: B drops valid, grant stays with B and A stalls
        b_valid = 1'b0; y_ready = 1'b0;
        #1;
        checks++; if (sel !== 1'b1 || a_ready !== 1'b0) begin failures++; $display("FAIL lock_stall actual=%b/%b expected=1/0", sel, a_ready); end
    endtask
`endif

    task automatic test_reset_midway();
`ifndef MUX_ARB_LOCK_EN
        // Load a lone A beat so prio = B and y_valid stays up
        y_ready = 1'b0; a_valid = 1'b1; a_data = 8'h77; b_valid = 1'b0;
        step();
        a_valid = 1'b0;
        #1;
        checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL mid_pre actual=%b expected=1", y_valid); end
`endif
        rst_n = 1'b0;
        #2;
        checks++; if (y_valid !== 1'b0 || y_data !== 8'h00) begin failures++; $display("FAIL mid_rst actual=%b/%h expected=0/00", y_valid, y_data); end
        checks++; if (sel !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_sel actual=%b/%b expected=0/0", sel, a_ready); end
        #3;
        rst_n = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hC1; b_data = 8'hD1;
        a_last = 1'b1; b_last = 1'b1; y_ready = 1'b1;
        #1;
        checks++; if (sel !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b0) begin failures++; $display("FAIL mid_prio actual=%b/%b/%b expected=0/1/0", sel, a_ready, b_ready); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL mid_no_out actual=%b expected=0", y_valid); end
        step();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'hC1) begin failures++; $display("FAIL mid_first actual=%b/%h expected=1/c1", y_valid, y_data); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_a();
        test_alternate();
        test_backpressure();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
